uart_rx_ctrl: RTL and testbench

//  Sequencer and buffer for the oversampling UART receive core. Generates the core's

---
 rtl/uart_rx_ctrl.sv | 134 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencer for the oversampling UART core: divider tick, one-cycle
// capture of each received byte into a small FIFO, and sticky/saturating status.
module uart_rx_ctrl #(
    parameter int Oversample = 16,
    parameter int FifoDepth  = 4,
    parameter int DivWidth   = 16
) (
    input  logic                           clk,
    input  logic                           nReset,
    input  logic                           rxEnable,
    input  logic [DivWidth-1:0]            baudDiv,
    input  logic                           flush,
    output logic                           rxEn,
    input  logic                           rxDone,
    input  logic                           rxErr,
    input  logic [7:0]                     rxData,
    output logic [7:0]                     outData,
    output logic                           outValid,
    input  logic                           outReady,
    output logic [$clog2(FifoDepth+1)-1:0] fifoCount,
    output logic                           overrun,
    output logic [7:0]                     frameErrCount,
    input  logic                           clearStatus
);

    localparam int PtrW = $clog2(FifoDepth);
    localparam int CntW = $clog2(FifoDepth + 1);

    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0 || Oversample < 1) begin : g_param_check
        $error("uart_rx_ctrl: FifoDepth must be a power of two >= 2 and Oversample >= 1");
    end

    logic [DivWidth-1:0] tick_cnt_reg;
    logic                rx_en_reg;
    logic                pending_reg;
    logic [7:0]          mem_reg [FifoDepth];
    logic [PtrW-1:0]     wr_ptr_reg;
    logic [PtrW-1:0]     rd_ptr_reg;
    logic [CntW-1:0]     count_reg;
    logic                overrun_reg;
    logic [7:0]          err_cnt_reg;

    logic                full;
    logic                pop;
    logic                push;
    logic                push_ok;
    logic                drop;
    logic [7:0]          err_base;
    logic [7:0]          err_next;

    // Tick generator: the counter is held at baudDiv while disabled, so a
    // re-enable always waits a full divider period before the first tick.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            tick_cnt_reg <= '0;
            rx_en_reg    <= 1'b0;
        end else if (!rxEnable) begin
            tick_cnt_reg <= baudDiv;
            rx_en_reg    <= 1'b0;
        end else if (tick_cnt_reg == '0) begin
            tick_cnt_reg <= baudDiv;
            rx_en_reg    <= 1'b1;
        end else begin
            tick_cnt_reg <= tick_cnt_reg - DivWidth'(1);
            rx_en_reg    <= 1'b0;
        end
    end

    assign outValid  = (count_reg != '0);
    assign fifoCount = count_reg;
    assign outData   = outValid ? mem_reg[rd_ptr_reg] : 8'h00;

    assign full    = (count_reg == CntW'(FifoDepth));
    assign pop     = outValid && outReady;
    assign push    = pending_reg && !flush;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    // The byte belonging to rxDone arrives one clock later, hence the pending flag.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            pending_reg <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                mem_reg[i] <= 8'h00;
            end
        end else if (flush) begin
            pending_reg <= 1'b0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
        end else begin
            pending_reg <= rxDone && !rxErr;
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= rxData;
                wr_ptr_reg          <= wr_ptr_reg + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CntW'(1);
                2'b01:   count_reg <= count_reg - CntW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Clear is applied before same-cycle events so a coincident event survives it.
    always_comb begin
        err_base = clearStatus ? 8'h00 : err_cnt_reg;
        err_next = err_base;
        if (rxErr && err_base != 8'hFF) begin
            err_next = err_base + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            overrun_reg <= 1'b0;
            err_cnt_reg <= 8'h00;
        end else begin
            overrun_reg <= (overrun_reg && !clearStatus) || drop;
            err_cnt_reg <= err_next;
        end
    end

    assign rxEn          = rx_en_reg;
    assign overrun       = overrun_reg;
    assign frameErrCount = err_cnt_reg;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed tick/reset/flush sequences, a
// per-cycle vector table for FIFO corners, and a queue-model random phase.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;
    localparam int DIVW  = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            nReset = 1'b0;
    logic            rxEnable = 1'b0;
    logic [DIVW-1:0] baudDiv = '0;
    logic            flush = 1'b0;
    logic            rxEn;
    logic            rxDone = 1'b0;
    logic            rxErr = 1'b0;
    logic [7:0]      rxData = 8'h00;
    logic [7:0]      outData;
    logic            outValid;
    logic            outReady = 1'b0;
    logic [CW-1:0]   fifoCount;
    logic            overrun;
    logic [7:0]      frameErrCount;
    logic            clearStatus = 1'b0;

    int total = 0;
    int passed = 0;

    uart_rx_ctrl #(
        .Oversample(16),
        .FifoDepth (DEPTH),
        .DivWidth  (DIVW)
    ) dut (
        .clk          (clk),
        .nReset       (nReset),
        .rxEnable     (rxEnable),
        .baudDiv      (baudDiv),
        .flush        (flush),
        .rxEn         (rxEn),
        .rxDone       (rxDone),
        .rxErr        (rxErr),
        .rxData       (rxData),
        .outData      (outData),
        .outValid     (outValid),
        .outReady     (outReady),
        .fifoCount    (fifoCount),
        .overrun      (overrun),
        .frameErrCount(frameErrCount),
        .clearStatus  (clearStatus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          done;
        logic [7:0]    data;
        logic          ready;
        logic          clear;
        logic          exp_valid;
        logic [7:0]    exp_data;
        logic [CW-1:0] exp_count;
        logic          exp_ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic dn, input logic [7:0] d, input logic rdy,
                                input logic clr, input logic ev, input logic [7:0] ed,
                                input int ec, input logic eo);
        vec_t v;
        v.done      = dn;
        v.data      = d;
        v.ready     = rdy;
        v.clear     = clr;
        v.exp_valid = ev;
        v.exp_data  = ed;
        v.exp_count = CW'(ec);
        v.exp_ov    = eo;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_fifo(input string tag, input logic ev, input logic [7:0] ed,
                            input logic [CW-1:0] ec, input logic eo);
        chk({tag, " outValid"}, 32'(outValid), 32'(ev));
        chk({tag, " outData"}, 32'(outData), 32'(ed));
        chk({tag, " fifoCount"}, 32'(fifoCount), 32'(ec));
        chk({tag, " overrun"}, 32'(overrun), 32'(eo));
    endtask

    task automatic chk_reset(input string tag);
        chk_fifo(tag, 1'b0, 8'h00, '0, 1'b0);
        chk({tag, " rxEn"}, 32'(rxEn), 32'd0);
        chk({tag, " frameErrCount"}, 32'(frameErrCount), 32'd0);
    endtask

    task automatic quiet();
        rxDone = 1'b0; rxErr = 1'b0; rxData = 8'h00; outReady = 1'b0;
        flush = 1'b0; clearStatus = 1'b0;
    endtask

    // Random-phase reference model: FIFO contents as a queue of bytes.
    logic [7:0] q[$];
    logic       m_pend;
    logic       m_ov;
    int         m_fe;

    initial begin
        int div;
        logic pop_now;
        logic was_full;

        // ---- reset values ----
        cyc(); cyc();
        chk_reset("reset");
        nReset = 1'b1;
        cyc();
        chk_reset("post-reset idle");

        // ---- tick generator, baudDiv=3 ----
        baudDiv = 16'd3;
        cyc();
        rxEnable = 1'b1;
        for (int n = 0; n < 12; n++) begin
            cyc();
            chk($sformatf("tick div3 n%0d", n), 32'(rxEn), 32'((n % 4) == 3));
        end
        rxEnable = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cyc();
            chk($sformatf("tick disabled n%0d", n), 32'(rxEn), 32'd0);
        end
        rxEnable = 1'b1;
        for (int n = 0; n < 8; n++) begin
            cyc();
            chk($sformatf("tick reenable n%0d", n), 32'(rxEn), 32'((n % 4) == 3));
        end
        rxEnable = 1'b0;
        baudDiv  = 16'd0;
        cyc();
        rxEnable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cyc();
            chk($sformatf("tick div0 n%0d", n), 32'(rxEn), 32'd1);
        end
        rxEnable = 1'b0;
        cyc();

        // ---- vector table: single byte, overrun, full push+pop with wrap ----
        //               done data  rdy clr  valid data cnt ov
        tbl.push_back(mk(1, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'hA5, 1, 0, 1, 8'hA5, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h01, 0, 0, 1, 8'h01, 1, 0));
        tbl.push_back(mk(1, 8'h02, 0, 0, 1, 8'h01, 2, 0));
        tbl.push_back(mk(1, 8'h03, 0, 0, 1, 8'h01, 3, 0));
        tbl.push_back(mk(1, 8'h04, 0, 0, 1, 8'h01, 4, 0));
        tbl.push_back(mk(1, 8'h05, 0, 0, 1, 8'h01, 4, 1));
        tbl.push_back(mk(0, 8'h06, 0, 1, 1, 8'h01, 4, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8'h01, 4, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h02, 3, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h03, 2, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h04, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'h11, 0, 0, 1, 8'h11, 1, 0));
        tbl.push_back(mk(1, 8'h12, 0, 0, 1, 8'h11, 2, 0));
        tbl.push_back(mk(1, 8'h13, 0, 0, 1, 8'h11, 3, 0));
        tbl.push_back(mk(1, 8'h14, 0, 0, 1, 8'h11, 4, 0));
        tbl.push_back(mk(1, 8'h15, 1, 0, 1, 8'h12, 4, 0));
        tbl.push_back(mk(0, 8'h16, 1, 0, 1, 8'h13, 4, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h14, 3, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h15, 2, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 8'h16, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            rxDone      = tbl[i].done;
            rxData      = tbl[i].data;
            outReady    = tbl[i].ready;
            clearStatus = tbl[i].clear;
            cyc();
            chk_fifo($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_data,
                     tbl[i].exp_count, tbl[i].exp_ov);
        end
        quiet();

        // ---- framing errors: saturation, never pushed, clear+err ----
        rxErr  = 1'b1;
        rxDone = 1'b1;
        for (int n = 0; n < 300; n++) cyc();
        chk("frameErr saturate", 32'(frameErrCount), 32'd255);
        rxErr  = 1'b0;
        rxDone = 1'b0;
        cyc();
        chk("error byte not pushed", 32'(fifoCount), 32'd0);
        chk("frameErr hold", 32'(frameErrCount), 32'd255);
        clearStatus = 1'b1;
        rxErr       = 1'b1;
        cyc();
        chk("clear+rxErr", 32'(frameErrCount), 32'd1);
        rxErr = 1'b0;
        cyc();
        chk("clear alone", 32'(frameErrCount), 32'd0);
        quiet();

        // ---- async reset mid-frame and mid-drain ----
        baudDiv  = 16'd3;
        rxEnable = 1'b1;
        rxDone   = 1'b1;
        cyc();
        rxData = 8'h21;
        cyc();
        rxData = 8'h22;
        rxErr  = 1'b1;
        cyc();
        rxErr    = 1'b0;
        rxDone   = 1'b1;
        outReady = 1'b1;
        rxData   = 8'h23;
        #2;
        nReset = 1'b0;
        #1;
        chk_reset("async reset");
        cyc();
        chk_reset("reset held");
        quiet();
        rxEnable = 1'b0;
        nReset   = 1'b1;
        cyc();
        chk_reset("after release");

        // ---- flush while full with a same-cycle push ----
        rxDone = 1'b1;
        cyc();
        for (int i = 1; i <= DEPTH; i++) begin
            rxData = 8'(8'h30 + i);
            cyc();
        end
        chk_fifo("prefill", 1'b1, 8'h31, CW'(DEPTH), 1'b0);
        rxDone = 1'b0;
        rxData = 8'h77;
        flush  = 1'b1;
        cyc();
        chk_fifo("flush+push", 1'b0, 8'h00, '0, 1'b0);
        flush = 1'b0;
        cyc();
        chk_fifo("after flush", 1'b0, 8'h00, '0, 1'b0);

        // ---- randomized phase against queue model ----
        div         = $urandom_range(0, 6);
        baudDiv     = DIVW'(div);
        flush       = 1'b1;
        clearStatus = 1'b1;
        cyc();
        quiet();
        q.delete();
        m_pend = 1'b0;
        m_ov   = 1'b0;
        m_fe   = 0;
        rxEnable = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rxDone      = ($urandom_range(0, 9) < 4);
            rxErr       = ($urandom_range(0, 19) == 0);
            rxData      = 8'($urandom);
            outReady    = ($urandom_range(0, 9) < 4);
            flush       = ($urandom_range(0, 49) == 0);
            clearStatus = ($urandom_range(0, 39) == 0);

            pop_now  = (q.size() > 0) && outReady;
            was_full = (q.size() == DEPTH);
            if (clearStatus) begin
                m_ov = 1'b0;
                m_fe = 0;
            end
            if (rxErr && m_fe < 255) m_fe++;
            if (flush) begin
                q.delete();
            end else begin
                if (pop_now) void'(q.pop_front());
                if (m_pend) begin
                    if (was_full && !pop_now) m_ov = 1'b1;
                    else q.push_back(rxData);
                end
            end
            m_pend = !flush && rxDone && !rxErr;

            cyc();
            chk_fifo($sformatf("rand%0d", n), q.size() > 0,
                     (q.size() > 0) ? q[0] : 8'h00, CW'(q.size()), m_ov);
            chk($sformatf("rand%0d frameErrCount", n), 32'(frameErrCount), 32'(m_fe));
            chk($sformatf("rand%0d rxEn", n), 32'(rxEn), 32'((n % (div + 1)) == div));
        end
        quiet();
        rxEnable = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
